traffic_light_controller: RTL and testbench
===========================================

Name: traffic_light_controller

Overview:
- Sequential two-approach traffic-light controller.
- Consumes the four vehicle-presence sensors (sa1, sa2 on approach A; sb1, sb2 on approach B) and drives red/orange/green for both approaches through timed phases.
- Replaces the combinational light decoder as the sensor-responding end of the intersection interface; sits between the sensor front-end and the lamp drivers.

Parameters:
- GREEN_MIN, 4, minimum green duration in clk cycles when the opposing approach has demand.
- GREEN_MAX, 8, maximum green duration in clk cycles when the own approach is heavy (both sensors set) and the opposing approach has demand.
- ORANGE_T, 2, orange duration in clk cycles.
- ALLRED_T, 1, all-red clearance duration in clk cycles.
- CNT_W, 8, phase timer width.
- Legal values: 1 <= GREEN_MIN <= GREEN_MAX < 2**CNT_W; ORANGE_T >= 1; ALLRED_T >= 1. Out-of-range values are an elaboration-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- sa1  input  1  approach A sensor 1 (vehicle at stop line).
- sa2  input  1  approach A sensor 2 (queue sensor).
- sb1  input  1  approach B sensor 1.
- sb2  input  1  approach B sensor 2.
- ra, oa, ga  output  1 each  approach A red/orange/green.
- rb, ob, gb  output  1 each  approach B red/orange/green.
- phase  output  3  current state code, for debug and verification.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Sensor registration: sensors are registered once (1-cycle latency).
  - demand_x = sx1 | sx2
  - heavy_x = sx1 & sx2
- States and codes:
  - ALLRED_BA = 0
  - A_GREEN = 1
  - A_ORANGE = 2
  - ALLRED_AB = 3
  - B_GREEN = 4
  - B_ORANGE = 5
  - Codes 6 and 7 are illegal and recover to ALLRED_BA on the next edge.
- Reset: state = ALLRED_BA, timer = 0, sensor registers = 0.
  - Outputs during and immediately after reset: ra = rb = 1; all others 0; phase = 0.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 each cycle.
  - Saturates at 2**CNT_W - 1; never wraps.
- Outputs:
  - Moore-decoded from the state register only; no sensor-to-light combinational path.
  - Exactly one lamp per approach is lit in every cycle.
  - Approach A light: ga in A_GREEN; oa in A_ORANGE; ra in all other states.
  - Approach B light: gb in B_GREEN; ob in B_ORANGE; rb in all other states.
  - ga and gb are never both set. A green is never adjacent to B non-red, and vice versa.
- Transitions (t = timer value in the current cycle):
  - ALLRED_BA -> A_GREEN when t == ALLRED_T-1.
  - A_GREEN -> A_ORANGE when demand_b && t >= GREEN_MIN-1 && (!heavy_a || t >= GREEN_MAX-1).
  - A_ORANGE -> ALLRED_AB when t == ORANGE_T-1.
  - ALLRED_AB -> B_GREEN when t == ALLRED_T-1.
  - B_GREEN -> B_ORANGE is symmetric with demand_a and heavy_b.
  - B_ORANGE -> ALLRED_BA when t == ORANGE_T-1.
- Boundary conditions:
  - No opposing demand: green holds indefinitely, and the timer saturates.
  - Demand already present at green entry: the green lasts exactly GREEN_MIN cycles, or GREEN_MAX cycles if heavy throughout.
  - Heavy drops mid-extension with t >= GREEN_MIN-1: exit in that same cycle.
  - Demand withdrawn during orange or all-red: the sequence still completes into the opposite green. Once orange starts, there is no abort.
  - Both approaches demanding continuously: strict alternation A, B, A, ...
  - Reset asserted in any state: the next cycle is ALLRED_BA with all lamps red. A gets green first after release.

Decomposition:
- Package traffic_light_pkg:
  - phase_t state enum with the codes above.
  - Lamp-vector constants LAMP_RED = 3'b100, LAMP_ORANGE = 3'b010, LAMP_GREEN = 3'b001 (order r,o,g).
- One natural sub-module, phase_timer: clear, increment, saturate, CNT_W parameter.
- The FSM and decode stay in the top module.

Test Plan:
- Defaults throughout (GREEN_MIN=4, GREEN_MAX=8, ORANGE_T=2, ALLRED_T=1).
- Reset release, all sensors 0 -> 1 cycle ra=rb=1 (phase 0), then ga=1, rb=1; ga held for 50 cycles with no change.
- sb1=1 held from reset -> ga exactly 4 cycles, oa 2, all-red 1, then gb=1 (phase 4); with sa1=0, gb holds.
- sa1=sa2=1 and sb1=1 held -> ga lasts 8 cycles; then gb lasts 4 cycles (B not heavy, A demanding); alternation repeats.
- sa1=sa2=1, sb2=1; drop sa2 at green timer=5 -> oa asserted on the edge after timer=5; green length 6.
- sb1 pulsed for 1 cycle only, after GREEN_MIN -> full A_ORANGE, ALLRED_AB, B_GREEN sequence completes despite demand vanishing.
- rst pulsed for 1 cycle while phase=5 (B_ORANGE) -> next cycle ra=rb=1, phase=0, then ga; checker asserts one lamp per approach every cycle.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types, lamp encodings and lamp decode helpers for the
// two-approach traffic-light controller.
package traffic_light_pkg;

    // Controller phase; the code doubles as the debug "phase" output.
    typedef enum logic [2:0] {
        ALLRED_BA = 3'd0,
        A_GREEN   = 3'd1,
        A_ORANGE  = 3'd2,
        ALLRED_AB = 3'd3,
        B_GREEN   = 3'd4,
        B_ORANGE  = 3'd5
    } phase_t;

    // Lamp vectors, bit order {red, orange, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_ORANGE = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Approach A lamp for a given phase; red whenever A is not running.
    function automatic logic [2:0] lamps_a(input phase_t p);
        case (p)
            A_GREEN:  return LAMP_GREEN;
            A_ORANGE: return LAMP_ORANGE;
            default:  return LAMP_RED;
        endcase
    endfunction

    // Approach B lamp for a given phase; red whenever B is not running.
    function automatic logic [2:0] lamps_b(input phase_t p);
        case (p)
            B_GREEN:  return LAMP_GREEN;
            B_ORANGE: return LAMP_ORANGE;
            default:  return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, clears on a
// phase change and saturates at all-ones so long greens never wrap.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Clear, increment or hold at saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CNT_ZERO;
        end else if (clear) begin
            count <= CNT_ZERO;
        end else if (count != CNT_MAX) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Two-approach traffic-light controller: registered sensors feed a timed
// phase FSM; lamps are decoded from the phase only (never from sensors).
module traffic_light_controller
    import traffic_light_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int ORANGE_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sa1,
    input  logic       sa2,
    input  logic       sb1,
    input  logic       sb2,
    output logic       ra,
    output logic       oa,
    output logic       ga,
    output logic       rb,
    output logic       ob,
    output logic       gb,
    output logic [2:0] phase
);

    if (GREEN_MIN < 1 || GREEN_MIN > GREEN_MAX || GREEN_MAX >= (2 ** CNT_W) ||
        ORANGE_T < 1 || ALLRED_T < 1) begin : g_bad_params
        $error("traffic_light_controller: illegal timing parameters");
    end

    // Last timer value of each timed interval (t counts from 0).
    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] ORANGE_LAST = CNT_W'(ORANGE_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

    logic             sa1_r, sa2_r, sb1_r, sb2_r;
    logic             demand_a_s, demand_b_s, heavy_a_s, heavy_b_s;
    phase_t           state_r, state_nxt_s;
    logic             timer_clear_s;
    logic [CNT_W-1:0] timer_s;
    logic [2:0]       lamp_a_r, lamp_b_r;

    // Register the raw sensors once before they reach the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa1_r <= 1'b0;
            sa2_r <= 1'b0;
            sb1_r <= 1'b0;
            sb2_r <= 1'b0;
        end else begin
            sa1_r <= sa1;
            sa2_r <= sa2;
            sb1_r <= sb1;
            sb2_r <= sb2;
        end
    end

    assign demand_a_s = sa1_r | sa2_r;
    assign demand_b_s = sb1_r | sb2_r;
    assign heavy_a_s  = sa1_r & sa2_r;
    assign heavy_b_s  = sb1_r & sb2_r;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear_s),
        .count (timer_s)
    );

    // Phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ALLRED_BA;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-phase logic; a green ends only on opposing demand after the
    // minimum, extended to the maximum while its own approach stays heavy.
    always_comb begin
        state_nxt_s   = state_r;
        timer_clear_s = 1'b0;
        case (state_r)
            ALLRED_BA: begin
                if (timer_s == ALLRED_LAST) state_nxt_s = A_GREEN;
                else                        state_nxt_s = ALLRED_BA;
            end
            A_GREEN: begin
                if (demand_b_s && timer_s >= GMIN_LAST &&
                    (!heavy_a_s || timer_s >= GMAX_LAST)) state_nxt_s = A_ORANGE;
                else                                      state_nxt_s = A_GREEN;
            end
            A_ORANGE: begin
                if (timer_s == ORANGE_LAST) state_nxt_s = ALLRED_AB;
                else                        state_nxt_s = A_ORANGE;
            end
            ALLRED_AB: begin
                if (timer_s == ALLRED_LAST) state_nxt_s = B_GREEN;
                else                        state_nxt_s = ALLRED_AB;
            end
            B_GREEN: begin
                if (demand_a_s && timer_s >= GMIN_LAST &&
                    (!heavy_b_s || timer_s >= GMAX_LAST)) state_nxt_s = B_ORANGE;
                else                                      state_nxt_s = B_GREEN;
            end
            B_ORANGE: begin
                if (timer_s == ORANGE_LAST) state_nxt_s = ALLRED_BA;
                else                        state_nxt_s = B_ORANGE;
            end
            default: begin
                state_nxt_s = ALLRED_BA;
            end
        endcase
        if (state_nxt_s != state_r) timer_clear_s = 1'b1;
        else                        timer_clear_s = 1'b0;
    end

    // Lamp registers loaded with the decode of the phase being entered,
    // so they always match the phase register and stay glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_a_r <= LAMP_RED;
            lamp_b_r <= LAMP_RED;
        end else begin
            lamp_a_r <= lamps_a(state_nxt_s);
            lamp_b_r <= lamps_b(state_nxt_s);
        end
    end

    assign {ra, oa, ga} = lamp_a_r;
    assign {rb, ob, gb} = lamp_b_r;
    assign phase        = state_r;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench: per-cycle vectors of {rst, sensors, expected phase},
// with expected values passed through a scoreboard queue to the sampler.
module tb_traffic_light_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sa1 = 1'b0, sa2 = 1'b0, sb1 = 1'b0, sb2 = 1'b0;
    logic       ra, oa, ga, rb, ob, gb;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] sens;   // {sa1, sa2, sb1, sb2}
        logic [2:0] phase;  // expected phase after the edge
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];

    localparam logic [3:0] S_NONE  = 4'b0000;
    localparam logic [3:0] S_B1    = 4'b0010;
    localparam logic [3:0] S_AH_B1 = 4'b1110;
    localparam logic [3:0] S_AH_B2 = 4'b1101;
    localparam logic [3:0] S_A1_B2 = 4'b1001;
    localparam logic [3:0] S_A1_B1 = 4'b1010;

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk   (clk),
        .rst   (rst),
        .sa1   (sa1),
        .sa2   (sa2),
        .sb1   (sb1),
        .sb2   (sb2),
        .ra    (ra),
        .oa    (oa),
        .ga    (ga),
        .rb    (rb),
        .ob    (ob),
        .gb    (gb),
        .phase (phase)
    );

    function automatic logic [2:0] lamp_of(input logic [2:0] p, input logic [2:0] g,
                                           input logic [2:0] o);
        if (p == g)      return 3'b001;
        else if (p == o) return 3'b010;
        else             return 3'b100;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add_run(input logic r, input logic [3:0] s, input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{r, s, p});
    endtask

    task automatic apply(input logic r, input logic [3:0] s, input logic [2:0] p);
        logic [2:0] e;
        @(negedge clk);
        rst = r;
        {sa1, sa2, sb1, sb2} = s;
        exp_q.push_back(p);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("phase",   {5'd0, phase},      {5'd0, e});
        check("lamps_a", {5'd0, ra, oa, ga}, {5'd0, lamp_of(e, 3'd1, 3'd2)});
        check("lamps_b", {5'd0, rb, ob, gb}, {5'd0, lamp_of(e, 3'd4, 3'd5)});
        check("one_lamp_per_approach",
              {6'd0, ($countones({ra, oa, ga}) == 1), ($countones({rb, ob, gb}) == 1)},
              8'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release with no demand: one all-red cycle, then A green held.
        apply(1'b1, S_NONE, 3'd0);
        apply(1'b1, S_NONE, 3'd0);
        for (int i = 0; i < 51; i++) apply(1'b0, S_NONE, 3'd1);

        // sb1 held from reset: A green 4, orange 2, all-red 1, B green holds.
        add_run(1'b1, S_B1, 3'd0, 1);
        add_run(1'b0, S_B1, 3'd1, 4);
        add_run(1'b0, S_B1, 3'd2, 2);
        add_run(1'b0, S_B1, 3'd3, 1);
        add_run(1'b0, S_B1, 3'd4, 6);

        // A heavy, B light demand: A green 8, B green 4, alternation repeats.
        add_run(1'b1, S_AH_B1, 3'd0, 1);
        add_run(1'b0, S_AH_B1, 3'd1, 8);
        add_run(1'b0, S_AH_B1, 3'd2, 2);
        add_run(1'b0, S_AH_B1, 3'd3, 1);
        add_run(1'b0, S_AH_B1, 3'd4, 4);
        add_run(1'b0, S_AH_B1, 3'd5, 2);
        add_run(1'b0, S_AH_B1, 3'd0, 1);
        add_run(1'b0, S_AH_B1, 3'd1, 8);
        add_run(1'b0, S_AH_B1, 3'd2, 2);
        add_run(1'b0, S_AH_B1, 3'd3, 1);
        add_run(1'b0, S_AH_B1, 3'd4, 4);

        // Heavy drops while extending (registered low at t=5): green lasts 6.
        add_run(1'b1, S_AH_B2, 3'd0, 1);
        add_run(1'b0, S_AH_B2, 3'd1, 5);
        add_run(1'b0, S_A1_B2, 3'd1, 1);
        add_run(1'b0, S_A1_B2, 3'd2, 2);
        add_run(1'b0, S_A1_B2, 3'd3, 1);
        add_run(1'b0, S_A1_B2, 3'd4, 4);
        add_run(1'b0, S_A1_B2, 3'd5, 2);
        add_run(1'b0, S_A1_B2, 3'd0, 1);
        add_run(1'b0, S_A1_B2, 3'd1, 4);
        add_run(1'b0, S_A1_B2, 3'd2, 1);

        // One-cycle sb1 pulse after the minimum: the handover still completes.
        add_run(1'b1, S_NONE, 3'd0, 1);
        add_run(1'b0, S_NONE, 3'd1, 6);
        add_run(1'b0, S_B1,   3'd1, 1);
        add_run(1'b0, S_NONE, 3'd2, 2);
        add_run(1'b0, S_NONE, 3'd3, 1);
        add_run(1'b0, S_NONE, 3'd4, 5);

        // Reset pulse while in B_ORANGE: all red next cycle, A green first.
        add_run(1'b1, S_A1_B1, 3'd0, 1);
        add_run(1'b0, S_A1_B1, 3'd1, 4);
        add_run(1'b0, S_A1_B1, 3'd2, 2);
        add_run(1'b0, S_A1_B1, 3'd3, 1);
        add_run(1'b0, S_A1_B1, 3'd4, 4);
        add_run(1'b0, S_A1_B1, 3'd5, 1);
        add_run(1'b1, S_A1_B1, 3'd0, 1);
        add_run(1'b0, S_A1_B1, 3'd1, 4);
        add_run(1'b0, S_A1_B1, 3'd2, 1);

        // Long green saturates the timer: a wrapped timer would read 0 here
        // and delay the exit, a saturated one leaves right away.
        add_run(1'b1, S_NONE, 3'd0, 1);
        add_run(1'b0, S_NONE, 3'd1, 256);
        add_run(1'b0, S_B1,   3'd1, 1);
        add_run(1'b0, S_B1,   3'd2, 1);

        foreach (vecs[i]) apply(vecs[i].rst, vecs[i].sens, vecs[i].phase);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
